// File: rtl/rv32_pkg.sv
// Shared rv32 pipeline types: the {pc, instr} pair carried from fetch to decode.
package rv32_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } rv32_prefetch_entry_t;

    localparam int ENTRY_W = $bits(rv32_prefetch_entry_t);

    // Instruction addresses are word granular; the low two bits never reach the bus.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/rv32_fifo.sv
// Generic synchronous FIFO with flush; power-of-two DEPTH so pointers wrap naturally.
module rv32_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[head];

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rv32_prefetch.sv
// Instruction prefetch queue: sequential pc generator and single-outstanding bus
// master feeding a FIFO of {pc, instr} pairs toward decode.
module rv32_prefetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'b0,
    parameter int          DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_in,
    input  logic [31:0]                flush_pc_in,
    input  logic                       stall_in,
    output logic [31:0]                instr_address_out,
    output logic                       instr_read_out,
    input  logic [31:0]                instr_read_value_in,
    input  logic                       instr_ready_in,
    output logic                       valid_out,
    output logic [31:0]                pc_out,
    output logic [31:0]                instr_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [31:0]          fetch_pc;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 push;
    logic                 pop;
    rv32_prefetch_entry_t push_entry;
    rv32_prefetch_entry_t head_entry;

    // The request depends only on registered occupancy, never on ready or pop.
    assign instr_read_out    = !reset && !flush_in && !fifo_full;
    assign instr_address_out = fetch_pc;
    assign push              = instr_read_out && instr_ready_in;
    assign pop               = valid_out && !stall_in;

    assign push_entry.pc    = fetch_pc;
    assign push_entry.instr = instr_read_value_in;

    assign valid_out = !reset && !fifo_empty;
    assign count_out = reset ? '0 : fifo_count;
    assign pc_out    = head_entry.pc;
    assign instr_out = head_entry.instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= word_align(RESET_VECTOR);
        end else if (flush_in) begin
            fetch_pc <= word_align(flush_pc_in);
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    rv32_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_in),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_rv32_prefetch.sv
// Directed bench for rv32_prefetch: memory returns address ^ KEY as instruction word.
module tb_rv32_prefetch;

    localparam logic [31:0] RV  = 32'h0000_1000;
    localparam logic [31:0] KEY = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_in;
    logic [31:0] flush_pc_in;
    logic        stall_in;
    logic [31:0] instr_address_out;
    logic        instr_read_out;
    logic [31:0] instr_read_value_in;
    logic        instr_ready_in;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic [2:0]  count_out;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign instr_read_value_in = instr_address_out ^ KEY;

    rv32_prefetch #(.RESET_VECTOR(RV), .DEPTH(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .flush_in            (flush_in),
        .flush_pc_in         (flush_pc_in),
        .stall_in            (stall_in),
        .instr_address_out   (instr_address_out),
        .instr_read_out      (instr_read_out),
        .instr_read_value_in (instr_read_value_in),
        .instr_ready_in      (instr_ready_in),
        .valid_out           (valid_out),
        .pc_out              (pc_out),
        .instr_out           (instr_out),
        .count_out           (count_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; flush_in = 0; flush_pc_in = 0; stall_in = 0; instr_ready_in = 1;
        step(); step();
        vectors++; if (instr_read_out !== 1'b0) begin miscompares++; $display("FAIL rst_read got %b want 0", instr_read_out); end
        vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", valid_out); end
        vectors++; if (count_out !== 3'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", count_out); end
        reset = 0; #1;
        vectors++; if (instr_read_out !== 1'b1) begin miscompares++; $display("FAIL post_rst_read got %b want 1", instr_read_out); end
        vectors++; if (instr_address_out !== 32'h0000_1000) begin miscompares++; $display("FAIL post_rst_addr got %h want 00001000", instr_address_out); end
        step();
        vectors++; if (instr_address_out !== 32'h0000_1004) begin miscompares++; $display("FAIL first_addr got %h want 00001004", instr_address_out); end
        vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL first_valid got %b want 1", valid_out); end
        vectors++; if (pc_out !== 32'h0000_1000) begin miscompares++; $display("FAIL first_pc got %h want 00001000", pc_out); end
        vectors++; if (instr_out !== 32'hA5A5_4A5A) begin miscompares++; $display("FAIL first_instr got %h want a5a54a5a", instr_out); end
        vectors++; if (count_out !== 3'd1) begin miscompares++; $display("FAIL first_count got %0d want 1", count_out); end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 3; i++) begin
            step();
            vectors++; if (instr_address_out !== RV + 32'(4*(i+1))) begin miscompares++; $display("FAIL stream_addr[%0d] got %h want %h", i, instr_address_out, RV + 32'(4*(i+1))); end
            vectors++; if (pc_out !== RV + 32'(4*i) || valid_out !== 1'b1) begin miscompares++; $display("FAIL stream_pc[%0d] got %h/%b want %h/1", i, pc_out, valid_out, RV + 32'(4*i)); end
            vectors++; if (count_out !== 3'd1) begin miscompares++; $display("FAIL stream_count[%0d] got %0d want 1", i, count_out); end
        end
    endtask

    task automatic test_full();
        flush_in = 1; flush_pc_in = 32'h0000_0100; stall_in = 1; #1;
        step();
        flush_in = 0; #1;
        vectors++; if (count_out !== 3'd0 || instr_address_out !== 32'h100) begin miscompares++; $display("FAIL full_start got %0d/%h want 0/00000100", count_out, instr_address_out); end
        for (int i = 1; i <= 4; i++) begin
            step();
            vectors++; if (count_out !== 3'(i)) begin miscompares++; $display("FAIL full_fill[%0d] got %0d want %0d", i, count_out, i); end
        end
        vectors++; if (instr_read_out !== 1'b0) begin miscompares++; $display("FAIL full_read got %b want 0", instr_read_out); end
        vectors++; if (instr_address_out !== 32'h110) begin miscompares++; $display("FAIL full_addr got %h want 00000110", instr_address_out); end
        vectors++; if (pc_out !== 32'h100) begin miscompares++; $display("FAIL full_head got %h want 00000100", pc_out); end
        stall_in = 0; #1;
        vectors++; if (instr_read_out !== 1'b0) begin miscompares++; $display("FAIL full_pop_read got %b want 0", instr_read_out); end
        step();
        stall_in = 1; #1;
        vectors++; if (count_out !== 3'd3) begin miscompares++; $display("FAIL release_count got %0d want 3", count_out); end
        vectors++; if (instr_read_out !== 1'b1 || instr_address_out !== 32'h110) begin miscompares++; $display("FAIL release_req got %b/%h want 1/00000110", instr_read_out, instr_address_out); end
        vectors++; if (pc_out !== 32'h104) begin miscompares++; $display("FAIL release_head got %h want 00000104", pc_out); end
    endtask

    task automatic test_full_pop();
        step();
        vectors++; if (count_out !== 3'd4 || instr_read_out !== 1'b0) begin miscompares++; $display("FAIL refill got %0d/%b want 4/0", count_out, instr_read_out); end
        stall_in = 0; #1;
        step();
        vectors++; if (count_out !== 3'd3 || pc_out !== 32'h108) begin miscompares++; $display("FAIL fullpop got %0d/%h want 3/00000108", count_out, pc_out); end
        vectors++; if (instr_address_out !== 32'h114) begin miscompares++; $display("FAIL fullpop_addr got %h want 00000114", instr_address_out); end
        for (int i = 1; i <= 3; i++) begin
            step();
            vectors++; if (pc_out !== 32'h108 + 32'(4*i) || instr_out !== ((32'h108 + 32'(4*i)) ^ KEY)) begin miscompares++; $display("FAIL seq_pc[%0d] got %h/%h want %h", i, pc_out, instr_out, 32'h108 + 32'(4*i)); end
            vectors++; if (count_out !== 3'd3) begin miscompares++; $display("FAIL seq_count[%0d] got %0d want 3", i, count_out); end
        end
    endtask

    task automatic test_flush();
        stall_in = 1; instr_ready_in = 0; #1;
        step();
        vectors++; if (count_out !== 3'd3) begin miscompares++; $display("FAIL preflush_count got %0d want 3", count_out); end
        flush_in = 1; flush_pc_in = 32'h0000_2003; instr_ready_in = 1; #1;
        vectors++; if (instr_read_out !== 1'b0) begin miscompares++; $display("FAIL flush_read got %b want 0", instr_read_out); end
        step();
        flush_in = 0; instr_ready_in = 0; #1;
        vectors++; if (count_out !== 3'd0 || valid_out !== 1'b0) begin miscompares++; $display("FAIL flush_clear got %0d/%b want 0/0", count_out, valid_out); end
        vectors++; if (instr_address_out !== 32'h2000 || instr_read_out !== 1'b1) begin miscompares++; $display("FAIL flush_addr got %h/%b want 00002000/1", instr_address_out, instr_read_out); end
        instr_ready_in = 1; stall_in = 0; #1;
        step();
        vectors++; if (valid_out !== 1'b1 || pc_out !== 32'h2000 || instr_out !== (32'h2000 ^ KEY)) begin miscompares++; $display("FAIL flush_first got %b/%h/%h want 1/00002000/%h", valid_out, pc_out, instr_out, 32'h2000 ^ KEY); end
    endtask

    task automatic test_wrap();
        flush_in = 1; flush_pc_in = 32'hFFFF_FFFC; instr_ready_in = 0; stall_in = 0; #1;
        step();
        flush_in = 0; #1;
        vectors++; if (instr_address_out !== 32'hFFFF_FFFC || instr_read_out !== 1'b1) begin miscompares++; $display("FAIL wrap_w0 got %h/%b want fffffffc/1", instr_address_out, instr_read_out); end
        step();
        vectors++; if (instr_address_out !== 32'hFFFF_FFFC || count_out !== 3'd0) begin miscompares++; $display("FAIL wrap_w1 got %h/%0d want fffffffc/0", instr_address_out, count_out); end
        instr_ready_in = 1; #1;
        vectors++; if (instr_address_out !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_w2 got %h want fffffffc", instr_address_out); end
        step();
        instr_ready_in = 0; #1;
        vectors++; if (instr_address_out !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_addr got %h want 00000000", instr_address_out); end
        vectors++; if (valid_out !== 1'b1 || pc_out !== 32'hFFFF_FFFC || instr_out !== (32'hFFFF_FFFC ^ KEY)) begin miscompares++; $display("FAIL wrap_head got %b/%h/%h want 1/fffffffc", valid_out, pc_out, instr_out); end
        step();
        vectors++; if (valid_out !== 1'b0 || instr_address_out !== 32'h0) begin miscompares++; $display("FAIL wrap_drain got %b/%h want 0/00000000", valid_out, instr_address_out); end
    endtask

    task automatic test_reset_midflight();
        flush_in = 1; flush_pc_in = 32'h0000_0300; stall_in = 1; instr_ready_in = 1; #1;
        step();
        flush_in = 0; #1;
        step(); step();
        instr_ready_in = 0; #1;
        vectors++; if (count_out !== 3'd2 || instr_read_out !== 1'b1 || instr_address_out !== 32'h308) begin miscompares++; $display("FAIL mid_pending got %0d/%b/%h want 2/1/00000308", count_out, instr_read_out, instr_address_out); end
        reset = 1; instr_ready_in = 1; #1;
        vectors++; if (instr_read_out !== 1'b0 || valid_out !== 1'b0 || count_out !== 3'd0) begin miscompares++; $display("FAIL mid_rst got %b/%b/%0d want 0/0/0", instr_read_out, valid_out, count_out); end
        step();
        reset = 0; instr_ready_in = 0; #1;
        vectors++; if (count_out !== 3'd0 || valid_out !== 1'b0) begin miscompares++; $display("FAIL mid_after got %0d/%b want 0/0", count_out, valid_out); end
        vectors++; if (instr_address_out !== RV || instr_read_out !== 1'b1) begin miscompares++; $display("FAIL mid_req got %h/%b want 00001000/1", instr_address_out, instr_read_out); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_full_pop();
        test_flush();
        test_wrap();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
